// File: rtl/dsp_pkg.sv
// Shared types and constants for the playback speed-control DSP stage.
package dsp_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SPEED_W  = 3;
  localparam int DIV_LAT  = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_PAUSE = 3'd4
  } dsp_state_e;

  // Clamp a widened sum back into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [SAMPLE_W+1:0] x);
    if (x > $signed({3'b000, {(SAMPLE_W-1){1'b1}}}))
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (x < $signed({3'b111, {(SAMPLE_W-1){1'b0}}}))
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return x[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/dsp_div.sv
// Sequential restoring divider: 20b signed dividend / 4b unsigned divisor,
// one quotient bit per cycle, truncating toward zero.
module dsp_div
  import dsp_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic signed [19:0] i_dividend,
  input  logic [3:0]         i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic signed [19:0] o_quot
);
  logic        r_busy, r_done, r_neg;
  logic [4:0]  r_cnt;
  logic [3:0]  r_rem, r_dvs;
  logic [19:0] r_q;
  logic [4:0]  w_shift, w_trial;

  assign w_shift = {r_rem, r_q[19]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_busy <= 1'b1;
        r_neg  <= i_dividend[19];
        r_q    <= i_dividend[19] ? 20'(-i_dividend) : i_dividend;
        r_rem  <= '0;
        r_dvs  <= i_divisor;
        r_cnt  <= 5'(DIV_LAT);
      end else if (r_busy) begin
        // Negative trial (bit 4 set) means the divisor did not fit: restore.
        if (!w_trial[4]) begin
          r_rem <= w_trial[3:0];
          r_q   <= {r_q[18:0], 1'b1};
        end else begin
          r_rem <= w_shift[3:0];
          r_q   <= {r_q[18:0], 1'b0};
        end
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_neg ? 20'(-r_q) : r_q;
endmodule

// File: rtl/dsp_speed_ctrl.sv
// Re-times SRAM samples to the DAC tick: fast mode decimates 1-of-N, slow mode
// stretches each sample over N ticks. DSP_LINEAR_INTERP_EN enables linear interpolation.
module dsp_speed_ctrl
  import dsp_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_play,
  input  logic                       i_stop,
  input  logic                       i_fast,
  input  logic [SPEED_W-1:0]         i_speed,
  output logic                       o_req,
  input  logic signed [SAMPLE_W-1:0] i_rdata,
  input  logic                       i_rvalid,
  input  logic                       i_end,
  input  logic                       i_dac_tick,
  output logic signed [SAMPLE_W-1:0] o_dac_data,
  output logic                       o_dac_valid,
  output logic                       o_done
);
  localparam logic [SPEED_W:0] N_ONE = (SPEED_W+1)'(1);

  dsp_state_e                 r_state, r_ret, w_nxt_wait;
  logic [SPEED_W:0]           r_n, r_fcnt, r_tcnt;
  logic                       r_fast, r_req, r_dac_valid, r_done;
  logic signed [SAMPLE_W-1:0] r_cur, r_dac_data, w_val;
  logic                       w_tick_acc, w_last_tick, w_grp_end, w_grp_start, w_more;

  assign w_tick_acc  = (r_state == S_OUT) && i_play && i_dac_tick && !i_stop;
  assign w_last_tick = r_fast || (r_n == N_ONE) || (r_tcnt + N_ONE == r_n);
  assign w_grp_end   = w_tick_acc && w_last_tick;
  assign w_grp_start = !i_stop && (((r_state == S_IDLE) && i_play) || w_grp_end);
  assign w_more      = r_fast && (r_fcnt + N_ONE < r_n);
  assign w_nxt_wait  = w_more ? S_FETCH : S_OUT;

`ifdef DSP_LINEAR_INTERP_EN
  logic signed [SAMPLE_W-1:0] r_prev;
  logic signed [19:0]         r_quot, w_quot, w_prod, w_diff20, w_k20;
  logic signed [SAMPLE_W:0]   w_diff;
  logic signed [SAMPLE_W+1:0] w_sum;
  logic                       r_qv, r_inflight, w_busy, w_done, w_go, w_interp;

  assign w_interp = !r_fast && (r_n != N_ONE);
  assign w_diff   = (SAMPLE_W+1)'(r_cur) - (SAMPLE_W+1)'(r_prev);
  assign w_diff20 = 20'(w_diff);
  assign w_k20    = 20'(r_tcnt + N_ONE);
  assign w_prod   = w_diff20 * w_k20;
  // Quotient for the next tick is launched once per tick slot, never alongside a tick.
  assign w_go     = (r_state == S_OUT) && w_interp && !r_qv && !r_inflight && !w_busy &&
                    !i_dac_tick && !i_stop;

  dsp_div u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_go),
    .i_dividend (w_prod),
    .i_divisor  (r_n),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prev     <= '0;
      r_quot     <= '0;
      r_qv       <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      if (w_go) r_inflight <= 1'b1;
      if (w_done && r_inflight) begin
        r_quot     <= w_quot;
        r_qv       <= 1'b1;
        r_inflight <= 1'b0;
      end
      if (w_tick_acc) r_qv <= 1'b0;
      if (w_grp_end) r_prev <= r_cur;
      // A division left running across a stop completes with r_inflight low and is discarded.
      if (i_stop || ((r_state == S_IDLE) && i_play)) begin
        r_prev     <= '0;
        r_qv       <= 1'b0;
        r_inflight <= 1'b0;
      end
    end
  end

  assign w_sum = (SAMPLE_W+2)'(r_prev) + (SAMPLE_W+2)'(r_quot);
  assign w_val = w_interp ? sat_sample(w_sum) : r_cur;
`else
  assign w_val = r_cur;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_ret       <= S_IDLE;
      r_n         <= N_ONE;
      r_fast      <= 1'b0;
      r_fcnt      <= '0;
      r_tcnt      <= '0;
      r_cur       <= '0;
      r_req       <= 1'b0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_req       <= 1'b0;
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;
      if (i_stop) begin
        r_state    <= S_IDLE;
        r_dac_data <= '0;
        r_fcnt     <= '0;
        r_tcnt     <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_FETCH: begin
            if (!i_play) begin
              r_state <= S_PAUSE;
              r_ret   <= S_FETCH;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_WAIT;
            end
          end
          // The outstanding request is always absorbed before honouring a pause.
          S_WAIT: begin
            if (i_rvalid) begin
              r_cur  <= i_rdata;
              r_fcnt <= r_fcnt + N_ONE;
              if (!i_play) begin
                r_state <= S_PAUSE;
                r_ret   <= w_nxt_wait;
              end else begin
                r_state <= w_nxt_wait;
              end
            end
          end
          S_OUT: begin
            if (!i_play) begin
              r_state <= S_PAUSE;
              r_ret   <= S_OUT;
            end else if (i_dac_tick) begin
              r_dac_data  <= w_val;
              r_dac_valid <= 1'b1;
              r_tcnt      <= r_tcnt + N_ONE;
              if (w_last_tick) begin
                r_fcnt <= '0;
                r_tcnt <= '0;
              end
            end
          end
          S_PAUSE: if (i_play) r_state <= r_ret;
          default: r_state <= S_IDLE;
        endcase
        if (w_grp_start) begin
          if (i_end) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_n     <= {1'b0, i_speed} + N_ONE;
            r_fast  <= i_fast;
          end
        end
      end
    end
  end

  assign o_req       = r_req;
  assign o_dac_data  = r_dac_data;
  assign o_dac_valid = r_dac_valid;
  assign o_done      = r_done;
endmodule

// File: tb/tb_dsp_speed_ctrl.sv
// Directed bench for dsp_speed_ctrl: SRAM responder, output monitor, hand-computed vectors.
module tb_dsp_speed_ctrl;
  import dsp_pkg::*;

  logic                       i_clk = 1'b0;
  logic                       i_rst = 1'b0;
  logic                       i_play = 1'b0, i_stop = 1'b0, i_fast = 1'b0, i_end = 1'b0;
  logic                       i_dac_tick = 1'b0;
  logic [SPEED_W-1:0]         i_speed = '0;
  logic                       o_req, o_dac_valid, o_done;
  logic signed [SAMPLE_W-1:0] o_dac_data;
  logic signed [SAMPLE_W-1:0] w_rdata;
  logic                       w_rvalid;

  logic                       m_rvalid = 1'b0, t_rvalid = 1'b0, mem_en = 1'b1;
  logic signed [SAMPLE_W-1:0] m_rdata = '0, t_rdata = '0;
  logic signed [SAMPLE_W-1:0] mem [0:15];
  int                         m_idx = 0;

  int                         n_req = 0, n_done = 0;
  logic signed [SAMPLE_W-1:0] outq [$];
  int                         n_chk = 0, n_bad = 0;
  int                         b_req, b_done, b_out;
  logic                       got;

  assign w_rvalid = m_rvalid | t_rvalid;
  assign w_rdata  = t_rvalid ? t_rdata : m_rdata;

  always #5 i_clk = ~i_clk;

  dsp_speed_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_play      (i_play),
    .i_stop      (i_stop),
    .i_fast      (i_fast),
    .i_speed     (i_speed),
    .o_req       (o_req),
    .i_rdata     (w_rdata),
    .i_rvalid    (w_rvalid),
    .i_end       (i_end),
    .i_dac_tick  (i_dac_tick),
    .o_dac_data  (o_dac_data),
    .o_dac_valid (o_dac_valid),
    .o_done      (o_done)
  );

  // SRAM stage: answers each request one cycle later, data in order from mem[].
  initial begin
    forever begin
      @(negedge i_clk);
      if (mem_en && o_req) begin
        @(posedge i_clk); #1;
        m_rdata  = mem[m_idx];
        m_rvalid = 1'b1;
        m_idx++;
        @(posedge i_clk); #1;
        m_rvalid = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_req)       n_req++;
      if (o_done)      n_done++;
      if (o_dac_valid) outq.push_back(o_dac_data);
    end
  end

  task automatic check(input string tag, input int got_v, input int exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got_v, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One DAC tick after a 200-cycle gap; optionally release play right behind it.
  task automatic tick(input bit drop);
    cyc(200);
    i_dac_tick = 1'b1;
    cyc(1);
    i_dac_tick = 1'b0;
    if (drop) i_play = 1'b0;
    cyc(5);
  endtask

  task automatic mark();
    b_req  = n_req;
    b_done = n_done;
    b_out  = outq.size();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    mem[0] = 16'sd100; mem[1] = 16'sd200; mem[2] = 16'sd300;
    for (int i = 0; i < 8; i++) mem[3+i] = 16'(i + 1);
    mem[11] = -16'sd400;
    mem[12] = 16'sd800;
    for (int i = 13; i < 16; i++) mem[i] = '0;

    #2;
    check("rst_req",   int'(o_req), 0);
    check("rst_valid", int'(o_dac_valid), 0);
    check("rst_done",  int'(o_done), 0);
    check("rst_data",  int'(o_dac_data), 0);
    cyc(2);
    i_rst = 1'b1;
    cyc(2);

    // N=1: one sample per tick
    mark();
    i_speed = 3'd0; i_fast = 1'b0; i_play = 1'b1;
    tick(0); tick(0);
    i_end = 1'b1;
    tick(1);
    i_end = 1'b0;
    check("n1_count", outq.size() - b_out, 3);
    check("n1_s0", int'(outq[b_out]), 100);
    check("n1_s1", int'(outq[b_out+1]), 200);
    check("n1_s2", int'(outq[b_out+2]), 300);
    check("n1_req", n_req - b_req, 3);
    check("n1_done", n_done - b_done, 1);
    tick(0);
    check("idle_tick_dropped", outq.size() - b_out, 3);
    check("idle_data_held", int'(o_dac_data), 300);

    // Fast N=4, with i_speed disturbed mid-group
    mark();
    i_speed = 3'd3; i_fast = 1'b1; i_play = 1'b1;
    cyc(2);
    i_speed = 3'd0;
    cyc(40);
    check("fast_req_g1", n_req - b_req, 4);
    i_speed = 3'd3;
    tick(0);
    cyc(40);
    check("fast_req_g2", n_req - b_req, 8);
    i_end = 1'b1;
    tick(1);
    i_end = 1'b0;
    check("fast_count", outq.size() - b_out, 2);
    check("fast_s0", int'(outq[b_out]), 4);
    check("fast_s1", int'(outq[b_out+1]), 8);
    check("fast_done", n_done - b_done, 1);

    // Slow N=4, prev=0, cur=-400
    mark();
    i_speed = 3'd3; i_fast = 1'b0; i_play = 1'b1;
    cyc(20);
    check("slow_req", n_req - b_req, 1);
    i_end = 1'b1;
    tick(0); tick(0); tick(0); tick(1);
    i_end = 1'b0;
    check("slow_count", outq.size() - b_out, 4);
    for (int k = 1; k <= 4; k++) begin
`ifdef DSP_LINEAR_INTERP_EN
      check($sformatf("slow_k%0d", k), int'(outq[b_out+k-1]), -100 * k);
`else
      check($sformatf("slow_k%0d", k), int'(outq[b_out+k-1]), -400);
`endif
    end
    check("slow_req_total", n_req - b_req, 1);
    check("slow_done", n_done - b_done, 1);

    // Pause mid-group for 5 ticks, then resume at the same k
    mark();
    i_speed = 3'd3; i_fast = 1'b0; i_play = 1'b1;
    tick(0);
    i_play = 1'b0;
    repeat (5) tick(0);
    check("pause_no_valid", outq.size() - b_out, 1);
    i_play = 1'b1;
    tick(0); tick(0);
    check("pause_no_early_done", n_done - b_done, 0);
    i_end = 1'b1;
    tick(1);
    i_end = 1'b0;
    check("pause_done", n_done - b_done, 1);
    check("pause_count", outq.size() - b_out, 4);
    for (int k = 1; k <= 4; k++) begin
`ifdef DSP_LINEAR_INTERP_EN
      check($sformatf("pause_k%0d", k), int'(outq[b_out+k-1]), 200 * k);
`else
      check($sformatf("pause_k%0d", k), int'(outq[b_out+k-1]), 800);
`endif
    end

    // End of recording at group start
    mark();
    i_end = 1'b1; i_play = 1'b1;
    cyc(1);
    i_play = 1'b0;
    cyc(5);
    i_end = 1'b0;
    check("end_done", n_done - b_done, 1);
    check("end_no_req", n_req - b_req, 0);

    // Stop in the same cycle as rvalid
    mark();
    mem_en = 1'b0;
    check("stop_pre_data", int'(o_dac_data), 800);
    i_play = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_req) begin
        got = 1'b1;
        break;
      end
    end
    check("stop_req_seen", int'(got), 1);
    @(posedge i_clk); #1;
    t_rdata = 16'sd1234; t_rvalid = 1'b1; i_stop = 1'b1; i_play = 1'b0;
    cyc(1);
    t_rvalid = 1'b0; i_stop = 1'b0;
    @(negedge i_clk);
    check("stop_data_zero", int'(o_dac_data), 0);
    cyc(10);
    check("stop_no_new_req", n_req - b_req, 1);
    tick(0);
    check("stop_no_valid", outq.size() - b_out, 0);
    check("stop_data_held", int'(o_dac_data), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
